imm_gen_stage: RTL and testbench

//  Pipelined RV32/RV64 immediate-decode stage with valid/ready handshake and 2-entry skid buffer.

---
 rtl/imm_gen_stage.sv | 211 +++++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// ---------------------------------------------------------------------------
// imm_gen_stage
//   Pipelined RV32/RV64 immediate-decode stage. A beat {in_instr, in_pc} is
//   decoded combinationally into a sign-extended immediate, its format code,
//   and a PC-relative target. The decoded result goes into a 2-entry skid
//   buffer (head + skid). The buffer drives the output through a
//   valid/ready handshake.
//
// Parameters
//   XLEN  datapath width, 32 or 64.
//   RV64  1: OP-IMM-32 decodes as I-format and OP-IMM shifts use a 6-bit
//         shamt. 0: OP-IMM-32 decodes as NONE and shifts use a 5-bit shamt.
//
// Ports
//   clk, rst_n        clock and synchronous active-low reset
//   flush             synchronous clear of the buffer; an accept on the same
//                     edge is dropped
//   in_valid/in_ready input handshake; in_ready depends only on state
//   in_instr, in_pc   instruction word and its address
//   out_valid/ready   output handshake
//   out_imm           sign-extended immediate (B/J are byte offsets)
//   out_fmt           0=I 1=S 2=B 3=U 4=J 7=NONE
//   out_target        pc+imm for B, J, AUIPC; 0 otherwise
// ---------------------------------------------------------------------------
module imm_gen_stage #(
  parameter int XLEN = 64,
  parameter bit RV64 = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target
);

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
  } entry_t;

  localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_NONE, target: '0};

  state_t state, state_nxt;
  entry_t head, head_nxt;
  entry_t skid;
  entry_t dec;
  logic   skid_load;
  logic   accept, pop;

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  logic        use_target;
  logic        is_shift;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned (inferred latch).
  always_comb begin
    imm32      = '0;
    dec.fmt    = FMT_NONE;
    use_target = 1'b0;
    unique case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        if (opcode == OP_IMM && is_shift) begin
          // Shift amounts are unsigned; bits above shamt hold funct7.
          imm32 = RV64 ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
        end
      end
      OP_IMM32: begin
        if (RV64) begin
          dec.fmt = FMT_I;
          imm32   = is_shift ? {27'b0, in_instr[24:20]}
                             : {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        dec.fmt    = FMT_B;
        use_target = 1'b1;
        imm32      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_LUI: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        dec.fmt    = FMT_U;
        use_target = 1'b1;
        imm32      = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.fmt    = FMT_J;
        use_target = 1'b1;
        imm32      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      end
      default: ;
    endcase
    // Size cast of a signed value replicates instr[31] up to XLEN (no-op at 32).
    dec.imm    = XLEN'($signed(imm32));
    dec.target = use_target ? (in_pc + dec.imm) : '0;
  end

  // -------------------------------------------------------------------------
  // Skid buffer control
  // -------------------------------------------------------------------------
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_load = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          head_nxt  = dec;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_nxt = dec;
        end else if (accept) begin
          skid_load = 1'b1;
          state_nxt = TWO;
        end else if (pop) begin
          head_nxt  = ENTRY_RST;
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_nxt  = skid;
          state_nxt = ONE;
        end
      end
      default: begin
        head_nxt  = ENTRY_RST;
        state_nxt = EMPTY;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state <= EMPTY;
      head  <= ENTRY_RST;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
    end
  end

  // NOTE: the skid entry is plain data qualified by state == TWO, so it needs
  // no reset; only the control state and the visible head are cleared.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid <= dec;
    end
  end

  assign out_imm    = head.imm;
  assign out_fmt    = head.fmt;
  assign out_target = head.target;

endmodule

// File: tb/tb_imm_gen_stage.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_stage
//   Directed vectors for imm_gen_stage (XLEN=64, RV64=1). The driver pushes
//   hand-computed expected results into a queue on each accepted beat; a
//   separate monitor pops and compares on each output transfer.
// ---------------------------------------------------------------------------
module tb_imm_gen_stage;

  localparam int XLEN = 64;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] target;
    string       name;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  imm_gen_stage #(.XLEN(XLEN), .RV64(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_fmt   (out_fmt),
    .out_target(out_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge when both are high.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, ".imm"},    out_imm,           e.imm);
          check({e.name, ".fmt"},    64'(out_fmt),      64'(e.fmt));
          check({e.name, ".target"}, out_target,        e.target);
        end
      end
    end
  end

  // Drive one beat and hold it until accepted (bounded).
  task automatic send(input string name, input logic [31:0] instr,
                      input logic [63:0] pc, input logic [63:0] imm,
                      input logic [2:0] fmt, input logic [63:0] target);
    exp_t e;
    bit   ok = 1'b0;
    e.imm = imm; e.fmt = fmt; e.target = target; e.name = name;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, ".accept_timeout"}, 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string name);
    check({name, ".out_valid"},  64'(out_valid),  64'd0);
    check({name, ".in_ready"},   64'(in_ready),   64'd1);
    check({name, ".out_fmt"},    64'(out_fmt),    64'd7);
    check({name, ".out_imm"},    out_imm,         64'd0);
    check({name, ".out_target"}, out_target,      64'd0);
  endtask

  // Fill the buffer (TWO) with out_ready low, then clear via flush or reset
  // while a new beat is offered; the offered beat must be dropped.
  task automatic clear_while_full(input bit use_reset, input string name);
    out_ready = 1'b0;
    send({name, "_a"}, 32'h00100093, 64'h0, 64'd1, 3'd0, 64'd0);
    send({name, "_b"}, 32'h00200093, 64'h0, 64'd2, 3'd0, 64'd0);
    check({name, ".full_in_ready"}, 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_instr = 32'h12345037;
    in_pc    = 64'h0;
    if (use_reset) rst_n = 1'b0; else flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    flush    = 1'b0;
    exp_q.delete();
    check_cleared(name);
    out_ready = 1'b1;
    idle(3);
    check({name, ".dropped"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    idle(3);
    rst_n = 1'b1;
    check_cleared("reset");

    // I-format, 1-cycle latency
    send("addi_m1", 32'hFFF00093, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 64'd0);
    check("latency.out_valid", 64'(out_valid), 64'd1);
    idle(1);
    send("sd",      32'h0021B423, 64'h100, 64'd8,                   3'd1, 64'd0);
    send("lui",     32'h12345037, 64'h100, 64'h12345000,            3'd3, 64'd0);
    send("beq_m4",  32'hFE000EE3, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 64'hFFC);
    send("jal",     32'h001000EF, 64'h2000, 64'h800,                3'd4, 64'h2800);
    send("slli63",  32'h03F09093, 64'h0,   64'd63,                  3'd0, 64'd0);
    send("none",    32'h00000000, 64'h40,  64'd0,                   3'd7, 64'd0);
    send("srai3",   32'h4030D093, 64'h0,   64'd3,                   3'd0, 64'd0);
    send("lw_min",  32'h80002083, 64'h0,   64'hFFFF_FFFF_FFFF_F800, 3'd0, 64'd0);
    send("addiw",   32'hFFF0809B, 64'h0,   64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 64'd0);
    send("auipc",   32'h00001097, 64'h4000, 64'h1000,               3'd3, 64'h5000);
    send("beq_wrap",32'hFE000EE3, 64'h0,   64'hFFFF_FFFF_FFFF_FFFC, 3'd2,
         64'hFFFF_FFFF_FFFF_FFFC);
    idle(3);

    // Backpressure: A,B fill the buffer, C stalls until release.
    out_ready = 1'b0;
    send("bp_a", 32'h00500093, 64'h0, 64'd5, 3'd0, 64'd0);
    send("bp_b", 32'h00600093, 64'h0, 64'd6, 3'd0, 64'd0);
    check("bp.in_ready_full", 64'(in_ready), 64'd0);
    fork
      send("bp_c", 32'h00700093, 64'h0, 64'd7, 3'd0, 64'd0);
      begin
        idle(3);
        check("bp.head_hold_imm", out_imm, 64'd5);
        check("bp.in_ready_stall", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    idle(4);

    clear_while_full(1'b0, "flush");
    clear_while_full(1'b1, "rst");

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    check("drain.queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
